// File: rtl/ifetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: issues sequential word fetches, queues in-order
// responses with their PC and hands them to decode; redirects flush and drop stale data.
module ifetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_ZERO  = CW'(0);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW:0]   C_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] P_ZERO  = PW'(0);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    logic          r_active;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];

    logic [CW:0]   w_occupancy;
    logic          w_credit;
    logic          w_accept;
    logic          w_has_data;
    logic          w_pop;
    logic          w_drop;
    logic          w_push;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   w_redirect_pc;

    // Credit, handshake decode and in-flight bookkeeping from registered state.
    always_comb begin
        w_occupancy   = {1'b0, r_count} + {1'b0, r_outstanding};
        w_credit      = r_active && (w_occupancy < C_DEPTH);
        w_accept      = w_credit && mem_gnt_i;
        w_has_data    = (r_count != C_ZERO);
        w_pop         = w_has_data && instr_ready_i;
        w_drop        = mem_rvalid_i && (r_discard != C_ZERO);
        w_push        = mem_rvalid_i && (r_discard == C_ZERO);
        // Everything still in flight after this cycle, including a same-cycle grant.
        w_inflight    = r_outstanding + (w_accept ? C_ONE : C_ZERO)
                                      - (mem_rvalid_i ? C_ONE : C_ZERO);
        w_count_nxt   = r_count + (w_push ? C_ONE : C_ZERO) - (w_pop ? C_ONE : C_ZERO);
        w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    end

    // Output drive; data/PC are forced to zero whenever the FIFO is empty.
    always_comb begin
        mem_req_o     = w_credit;
        mem_addr_o    = r_fetch_pc;
        instr_valid_o = w_has_data;
        if (w_has_data) begin
            instr_o    = r_fifo_data[r_rptr];
            instr_pc_o = r_fifo_pc[r_rptr];
        end else begin
            instr_o    = 32'h0000_0000;
            instr_pc_o = 32'h0000_0000;
        end
    end

    // Fetch/response PCs, counters, FIFO pointers and storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= C_ZERO;
            r_outstanding <= C_ZERO;
            r_discard     <= C_ZERO;
            r_wptr        <= P_ZERO;
            r_rptr        <= P_ZERO;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo_data[i] <= 32'h0000_0000;
                r_fifo_pc[i]   <= 32'h0000_0000;
            end
        end else begin
            r_active <= 1'b1;
            if (redirect_i) begin
                // Everything in flight becomes stale, including a same-cycle grant.
                r_fetch_pc    <= w_redirect_pc;
                r_resp_pc     <= w_redirect_pc;
                r_count       <= C_ZERO;
                r_wptr        <= P_ZERO;
                r_rptr        <= P_ZERO;
                r_outstanding <= w_inflight;
                r_discard     <= w_inflight;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                r_outstanding <= w_inflight;
                if (w_drop) begin
                    r_discard <= r_discard - C_ONE;
                end
                if (w_push) begin
                    r_fifo_data[r_wptr] <= mem_rdata_i;
                    r_fifo_pc[r_wptr]   <= r_resp_pc;
                    r_wptr              <= r_wptr + P_ONE;
                    r_resp_pc           <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + P_ONE;
                end
                r_count <= w_count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Self-checking bench for ifetch_prefetch_buffer: an in-order memory model with
// configurable latency/grant budget feeds an epoch-tagged scoreboard of expected instructions.
module tb_ifetch_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    ifetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] tag;
        logic [31:0] due;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    req_t        inflight_q[$];
    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cyc = 32'd0;
    logic [31:0] epoch = 32'd0;
    logic [31:0] grant_cnt = 32'd0;
    logic [31:0] gnt_limit = 32'd0;
    logic [31:0] lat = 32'd1;
    logic [31:0] pop_cnt = 32'd0;
    logic [31:0] ovf_cnt = 32'd0;
    logic [31:0] base_pops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0000_0013;
            32'h0000_0004: mem_word = 32'h0010_0093;
            32'h0000_0008: mem_word = 32'h0020_0113;
            default:       mem_word = a ^ 32'h5A00_0013;
        endcase
    endfunction

    // Drives memory inputs for the coming edge and scores the events that edge will see.
    task automatic model_step();
        req_t rsp;
        logic rsp_v;
        logic acc;
        logic pop_ev;
        int   pre;
        cyc++;
        if (rst == 1'b0) begin
            inflight_q.delete();
            exp_q.delete();
            grant_cnt    = 32'd0;
            epoch        = 32'd0;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
        end else begin
            chk("valid_vs_model", {31'b0, instr_valid_o}, {31'b0, (exp_q.size() != 0)});
            mem_gnt_i = (grant_cnt < gnt_limit);
            rsp_v = (inflight_q.size() > 0) && (inflight_q[0].due <= cyc);
            if (rsp_v) begin
                rsp          = inflight_q.pop_front();
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(rsp.addr);
            end else begin
                rsp          = '0;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = 32'h0;
            end
            acc    = mem_req_o && mem_gnt_i;
            pop_ev = instr_valid_o && instr_ready_i;
            pre    = exp_q.size();
            if (pop_ev && !redirect_i) begin
                if (pre == 0) begin
                    chk("pop_when_empty", {31'b0, instr_valid_o}, 32'h0);
                end else begin
                    chk("pop_pc", instr_pc_o, exp_q[0].pc);
                    chk("pop_instr", instr_o, exp_q[0].data);
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
            end
            if (rsp_v && (rsp.tag == epoch) && !redirect_i) begin
                if (pre >= DEPTH) ovf_cnt++;
                exp_q.push_back({rsp.addr, mem_rdata_i});
            end
            if (acc) begin
                inflight_q.push_back({mem_addr_o, epoch, cyc + lat});
                grant_cnt++;
            end
            if (redirect_i) begin
                epoch++;
                exp_q.delete();
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!instr_valid_o && k < 40) begin
            tick();
            k++;
        end
        chk(tag, {31'b0, instr_valid_o}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;

        // Reset state, then release with zero-wait memory.
        repeat (5) tick();
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);
        rst           = 1'b1;
        gnt_limit     = 32'hFFFF_FFFF;
        lat           = 32'd1;
        instr_ready_i = 1'b1;
        tick();
        chk("rel_req", {31'b0, mem_req_o}, 32'h1);
        chk("rel_addr", mem_addr_o, 32'h0);
        chk("rel_valid", {31'b0, instr_valid_o}, 32'h0);
        tick();
        chk("lat_valid_early", {31'b0, instr_valid_o}, 32'h0);
        tick();
        chk("lat_valid0", {31'b0, instr_valid_o}, 32'h1);
        chk("seq_pc0", instr_pc_o, 32'h0);
        chk("seq_w0", instr_o, 32'h0000_0013);
        tick();
        chk("seq_pc1", instr_pc_o, 32'h4);
        chk("seq_w1", instr_o, 32'h0010_0093);
        tick();
        chk("seq_pc2", instr_pc_o, 32'h8);
        chk("seq_w2", instr_o, 32'h0020_0113);

        // Consumer stalled: credit limit, then drain.
        instr_ready_i = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("full_grants", grant_cnt, 32'd4);
        chk("full_req", {31'b0, mem_req_o}, 32'h0);
        chk("full_addr", mem_addr_o, 32'h10);
        chk("full_head_pc", instr_pc_o, 32'h0);
        base_pops     = pop_cnt;
        instr_ready_i = 1'b1;
        repeat (4) tick();
        chk("drain_pops", pop_cnt - base_pops, 32'd4);
        repeat (6) tick();

        // Redirect with two slow responses in flight.
        lat       = 32'd3;
        gnt_limit = 32'd2;
        do_reset();
        repeat (2) tick();
        chk("slow_grants", grant_cnt, 32'd2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h20;
        tick();
        redirect_i = 1'b0;
        gnt_limit  = 32'hFFFF_FFFF;
        wait_valid("redir_timeout");
        chk("redir_pc", instr_pc_o, 32'h20);
        chk("redir_instr", instr_o, mem_word(32'h20));
        repeat (6) tick();

        // Grant stall: request held, address stable.
        lat       = 32'd1;
        gnt_limit = 32'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", {31'b0, mem_req_o}, 32'h1);
            chk("stall_addr", mem_addr_o, 32'h0);
            tick();
        end
        gnt_limit = grant_cnt + 32'd1;
        tick();
        chk("stall_adv_addr", mem_addr_o, 32'h4);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req2", {31'b0, mem_req_o}, 32'h1);
            chk("stall_addr2", mem_addr_o, 32'h4);
            tick();
        end
        chk("stall_grants", grant_cnt, 32'd1);

        // Redirect to a misaligned PC coincident with pop and response.
        gnt_limit = 32'hFFFF_FFFF;
        repeat (6) tick();
        chk("coinc_valid", {31'b0, instr_valid_o}, 32'h1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h22;
        tick();
        redirect_i = 1'b0;
        wait_valid("coinc_timeout");
        chk("coinc_pc", instr_pc_o, 32'h20);
        chk("coinc_instr", instr_o, mem_word(32'h20));
        repeat (5) tick();

        // Drain everything outstanding.
        gnt_limit = grant_cnt;
        for (int k = 0; k < 40 && (inflight_q.size() != 0 || exp_q.size() != 0); k++) begin
            tick();
        end
        tick();
        chk("drain_exp_q", exp_q.size(), 32'd0);
        chk("drain_valid", {31'b0, instr_valid_o}, 32'h0);

        // Reset in the middle of a stream.
        gnt_limit = 32'hFFFF_FFFF;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("mid_rst_valid", {31'b0, instr_valid_o}, 32'h0);
        chk("mid_rst_instr", instr_o, 32'h0);
        chk("mid_rst_pc", instr_pc_o, 32'h0);
        chk("mid_rst_addr", mem_addr_o, 32'h0);
        rst = 1'b1;
        tick();

        chk("no_fifo_overflow", ovf_cnt, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
